// File: rtl/mux_sel_arb_if.sv
// Request/grant bundle between the requesters and the 4-way mux arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface mux_sel_arb_if;
   logic [3:0] req;
   logic       done;
   logic       sel0;
   logic       sel1;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;

   modport master (
      output req, done,
      input  sel0, sel1, gnt, busy, timeout
   );

   modport slave (
      input  req, done,
      output sel0, sel1, gnt, busy, timeout
   );
endinterface

// File: rtl/mux_sel_arb.sv
// Round-robin arbiter for a 4x1 mux: grants one channel at a time.
// Each grant lasts until done or MAX_HOLD cycles, with all outputs registered.
//
// state | meaning
// IDLE  | no owner; pick next requester after last granted channel
// GRANT | channel sel_q owns the mux until done or hold limit
module mux_sel_arb #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   mux_sel_arb_if.slave       bus
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q;
   logic [1:0] last_q;
   logic [1:0] sel_q;
   logic [3:0] gnt_q;
   logic       busy_q;
   logic       timeout_q;
   logic [7:0] cnt_q;

   logic       pick_vld_d;
   logic [1:0] pick_idx_d;
   logic [1:0] cand;

   // Scan last+1 .. last+4 so the previous owner gets lowest priority.
   always_comb begin
      pick_vld_d = 1'b0;
      pick_idx_d = last_q;
      cand       = last_q;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!pick_vld_d && bus.req[cand]) begin
            pick_vld_d = 1'b1;
            pick_idx_d = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         last_q    <= 2'd3;
         sel_q     <= 2'd0;
         gnt_q     <= 4'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_vld_d) begin
                  state_q <= GRANT;
                  sel_q   <= pick_idx_d;
                  gnt_q   <= 4'b0001 << pick_idx_d;
                  busy_q  <= 1'b1;
                  cnt_q   <= 8'd0;
               end
            end
            GRANT: begin
               // done wins over the hold limit, so a late done is not a timeout
               if (bus.done || cnt_q == HOLD_LAST) begin
                  state_q   <= IDLE;
                  gnt_q     <= 4'd0;
                  busy_q    <= 1'b0;
                  last_q    <= sel_q;
                  timeout_q <= !bus.done;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sel0    = sel_q[0];
   assign bus.sel1    = sel_q[1];
   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arb.sv
// Scoreboard bench for mux_sel_arb: each stimulus cycle queues its expected
// output vector {gnt,sel1,sel0,busy,timeout}, compared once the edge has passed.
module tb_mux_sel_arb;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mux_sel_arb_if bus ();

   mux_sel_arb #(.MAX_HOLD(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   function automatic logic [7:0] mk(input logic [3:0] g, input int s, input logic t);
      logic [1:0] sv;
      sv = 2'(s);
      return {g, sv, (g != 4'd0), t};
   endfunction

   function automatic logic [3:0] oh(input int k);
      return 4'(1 << k);
   endfunction

   task automatic drive(input logic [3:0] r, input logic d, input logic [7:0] e);
      bus.req  = r;
      bus.done = d;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs_q.push_back({bus.gnt, bus.sel1, bus.sel0, bus.busy, bus.timeout});
   endtask

   // Structural invariants on every cycle once outputs are defined.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [1:0] idx;
         idx = 2'd0;
         for (int k = 0; k < 4; k++) if (bus.gnt[k]) idx = 2'(k);
         total++;
         if (((bus.gnt & (bus.gnt - 4'd1)) !== 4'd0) ||
             ((bus.gnt != 4'd0) && ({bus.sel1, bus.sel0} !== idx)) ||
             (bus.busy !== (bus.gnt != 4'd0))) begin
            bad++;
            $display("FAIL invariant t=%0t got gnt=%b sel=%b%b busy=%b want onehot gnt, sel=index, busy=|gnt",
                     $time, bus.gnt, bus.sel1, bus.sel0, bus.busy);
         end
      end
   end

   task automatic test_reset();
      int n = 0;
      reset_n = 1'b0;
      drive(4'hf, 1'b1, mk(4'd0, 0, 1'b0));
      chk_en = 1'b1;
      drive(4'h0, 1'b0, mk(4'd0, 0, 1'b0));
      reset_n = 1'b1;
      drive(4'h0, 1'b0, mk(4'd0, 0, 1'b0));
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   task automatic test_round_robin();
      int n = 0;
      for (int k = 0; k < 5; k++) begin
         drive(4'hf, 1'b0, mk(oh(k % 4), k % 4, 1'b0));
         drive(4'hf, 1'b1, mk(4'd0, k % 4, 1'b0));
      end
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL round_robin[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      drive(4'b0100, 1'b0, mk(4'b0100, 2, 1'b0));
      repeat (7) drive(4'h0, 1'b0, mk(4'b0100, 2, 1'b0));
      drive(4'h0, 1'b0, mk(4'd0, 2, 1'b1));
      drive(4'h0, 1'b0, mk(4'd0, 2, 1'b0));
      drive(4'h0, 1'b1, mk(4'd0, 2, 1'b0));
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL timeout[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   task automatic test_done_at_limit();
      int n = 0;
      drive(4'hf, 1'b0, mk(4'b1000, 3, 1'b0));
      repeat (7) drive(4'h0, 1'b0, mk(4'b1000, 3, 1'b0));
      drive(4'h0, 1'b1, mk(4'd0, 3, 1'b0));
      drive(4'h0, 1'b0, mk(4'd0, 3, 1'b0));
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL done_at_limit[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      drive(4'b1010, 1'b0, mk(4'b0010, 1, 1'b0));
      drive(4'b1010, 1'b1, mk(4'd0, 1, 1'b0));
      drive(4'b1010, 1'b0, mk(4'b1000, 3, 1'b0));
      drive(4'b1010, 1'b1, mk(4'd0, 3, 1'b0));
      drive(4'b1010, 1'b0, mk(4'b0010, 1, 1'b0));
      drive(4'h0, 1'b1, mk(4'd0, 1, 1'b0));
      drive(4'h0, 1'b1, mk(4'd0, 1, 1'b0));
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL wrap[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   task automatic test_reset_mid_grant();
      int n = 0;
      repeat (3) drive(4'b1000, 1'b0, mk(4'b1000, 3, 1'b0));
      reset_n = 1'b0;
      drive(4'b1000, 1'b0, mk(4'd0, 0, 1'b0));
      reset_n = 1'b1;
      drive(4'b1000, 1'b0, mk(4'b1000, 3, 1'b0));
      repeat (7) drive(4'h0, 1'b0, mk(4'b1000, 3, 1'b0));
      drive(4'h0, 1'b0, mk(4'd0, 3, 1'b1));
      drive(4'h0, 1'b0, mk(4'd0, 3, 1'b0));
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset_mid_grant[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   task automatic test_owner_drop();
      int n = 0;
      drive(4'b0001, 1'b0, mk(4'b0001, 0, 1'b0));
      repeat (3) drive(4'b1110, 1'b0, mk(4'b0001, 0, 1'b0));
      reset_n = 1'b0;
      #2;
      total++;
      if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL async_reset_glitch got gnt=%b busy=%b want gnt=0001 busy=1", bus.gnt, bus.busy);
      end
      reset_n = 1'b1;
      drive(4'b1110, 1'b0, mk(4'b0001, 0, 1'b0));
      drive(4'b1110, 1'b1, mk(4'd0, 0, 1'b0));
      drive(4'b1110, 1'b0, mk(4'b0010, 1, 1'b0));
      drive(4'b1110, 1'b1, mk(4'd0, 1, 1'b0));
      while (exp_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL owner_drop[%0d] got {gnt,sel,busy,to}=%b want %b", n, o, e); end
         n++;
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      bus.req  = 4'h0;
      bus.done = 1'b0;
      #1;
      test_reset();
      test_round_robin();
      test_timeout();
      test_done_at_limit();
      test_wrap();
      test_reset_mid_grant();
      test_owner_drop();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_sel_arb.md
MUX_SEL_ARB -- requirements
Module: mux_sel_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, maximum GRANT cycles per grant (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; synchronous and active-low (sampled only at rising clk).
REQ-004 SHALL have port req  input  4  per-channel request; bit k is requester k (k=0..3).
REQ-005 SHALL have port done  input  1  current owner finished; sampled only in GRANT.
REQ-006 SHALL have port sel0  output  1  LSB of granted channel index; drives the downstream 4x1 mux sel0.
REQ-007 SHALL have port sel1  output  1  MSB of granted channel index; drives the downstream 4x1 mux sel1.
REQ-008 SHALL have port gnt  output  4  one-hot grant; all zero when idle.
REQ-009 SHALL have port busy  output  1  high while in GRANT.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement two states: IDLE, GRANT; all outputs registered.
REQ-012 SHALL hold a 2-bit pointer last = index of most recently granted channel.
REQ-013 IDLE, req != 0: SHALL select the first set req bit scanning last+1, last+2, last+3, last+4 (mod 4, wrap 3->0).
REQ-014 After selection at edge N, SHALL present gnt one-hot, {sel1,sel0} = index, busy=1 from edge N (one-cycle latency from req sample); state -> GRANT.
REQ-015 IDLE, req == 0: SHALL stay in IDLE; gnt=0, busy=0; {sel1,sel0} hold the last granted index.
REQ-016 GRANT: SHALL keep gnt/sel constant regardless of req changes, including the owner dropping its req.
REQ-017 GRANT: SHALL count cycles in an 8-bit hold counter, cleared on grant entry; the first GRANT cycle has count 0.
REQ-018 GRANT, done=1: SHALL return to IDLE at the next edge (gnt=0, busy=0) and set last = owner index.
REQ-019 GRANT, done=0, count == MAX_HOLD-1: SHALL force release at the next edge (same as REQ-018) and assert timeout for exactly that one cycle.
REQ-020 done=1 in the same cycle as count == MAX_HOLD-1: SHALL be a normal release; timeout stays 0.
REQ-021 After any release, SHALL spend at least one cycle in IDLE (gnt=0) before the next grant; back-to-back grants are therefore 1 idle cycle apart.
REQ-022 done while in IDLE SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set; when gnt != 0, {sel1,sel0} SHALL equal the index of the set bit.

Reset
REQ-024 reset_n=0 at a rising edge SHALL force: state IDLE, gnt=0, busy=0, timeout=0, sel0=0, sel1=0, counter=0, last=3 (so channel 0 has first priority).
REQ-025 Reset SHALL override all other inputs, including mid-GRANT; the first grant decision is made on the first edge with reset_n=1.
REQ-026 Outputs SHALL be unaffected by reset_n between clock edges.

Verification
REQ-027 Reset then req=4'b1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0 with gnt=0001,0010,0100,1000,0001 and matching {sel1,sel0}=00,01,10,11,00.
REQ-028 Grant channel 2, done=0 for 8 cycles (MAX_HOLD=8) -> gnt=0100 for exactly 8 cycles, timeout=1 for one cycle coinciding with gnt=0 and busy=0, then last=2.
REQ-029 done=1 on the 8th GRANT cycle -> release with timeout=0.
REQ-030 last=3, req=4'b1010 -> grant ch1; after release with req=4'b1010 still held -> grant ch3 (wrap check), then ch1.
REQ-031 Assert reset_n=0 for one edge mid-GRANT on ch3 -> next cycle gnt=0, busy=0, sel=00; then req=4'b1000 -> ch3 granted, no stale counter (timeout after full MAX_HOLD cycles).
REQ-032 Owner drops req mid-GRANT, others request -> gnt unchanged until done; assertion checks on every cycle: gnt one-hot-or-zero, sel consistent with gnt, busy == (gnt != 0).
